// File: rtl/traffic_phase_scheduler.sv
// Actuated four-approach phase scheduler: round-robin arbitration among
// vehicle-detect requests, min/max bounded greens, yellow and all-red
// clearance, and an emergency preempt that forces one approach to green.
//
//   state  | meaning
//   IDLE   | no demand, all lamps red, waiting for a request or preempt
//   GREEN  | grant approach shows green, count = green cycles already shown
//   YELLOW | grant approach shows yellow for T_YELLOW cycles
//   ALLRED | all lamps red for T_ALLRED cycles; last cycle re-arbitrates
module traffic_phase_scheduler #(
  parameter int T_MIN_GREEN = 4,
  parameter int T_MAX_GREEN = 10,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int CW          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_dir,
  output logic [2:0] M1,
  output logic [2:0] M2,
  output logic [2:0] MT,
  output logic [2:0] SR,
  output logic [1:0] grant,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    ALLRED = 2'd3
  } phase_t;

  localparam logic [CW-1:0] MIN_LAST    = CW'(T_MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LAST    = CW'(T_MAX_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] ALLRED_LAST = CW'(T_ALLRED - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  phase_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [1:0]    grant_nxt;
  logic [1:0]    last, last_nxt;
  logic [11:0]   lamps, lamps_nxt;
  logic          win_valid;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic [3:0]    own;
  logic          others_pending;

  assign own            = 4'b0001 << grant;
  assign others_pending = |(req & ~own);

  // Arbiter: preempt wins outright, otherwise first request after the last served.
  always_comb begin
    win_valid = 1'b0;
    win       = last;
    idx       = '0;
    if (preempt) begin
      win_valid = 1'b1;
      win       = preempt_dir;
    end else begin
      for (int i = 1; i <= 4; i++) begin
        idx = last + i[1:0];
        if (!win_valid && req[idx]) begin
          win_valid = 1'b1;
          win       = idx;
        end
      end
    end
  end

  // Next-state, timer and grant logic.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (win_valid) begin
          state_nxt = GREEN;
          grant_nxt = win;
          last_nxt  = win;
        end
      end
      GREEN: begin
        if (preempt && (preempt_dir == grant)) begin
          count_nxt = count;
        end else if (preempt ||
                     ((count >= MIN_LAST) && !req[grant]) ||
                     ((count == MAX_LAST) && others_pending)) begin
          state_nxt = YELLOW;
          count_nxt = '0;
        end else if (count != MAX_LAST) begin
          count_nxt = count + 1'b1;
        end
      end
      YELLOW: begin
        if (count == YELLOW_LAST) begin
          state_nxt = ALLRED;
          count_nxt = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      ALLRED: begin
        if (count == ALLRED_LAST) begin
          count_nxt = '0;
          if (win_valid) begin
            state_nxt = GREEN;
            grant_nxt = win;
            last_nxt  = win;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // Lamp decode from the upcoming phase so lamps register on the same edge as state.
  always_comb begin
    lamps_nxt = {4{LAMP_RED}};
    for (int a = 0; a < 4; a++) begin
      if (a[1:0] == grant_nxt) begin
        if (state_nxt == GREEN)  lamps_nxt[3*a +: 3] = LAMP_GREEN;
        if (state_nxt == YELLOW) lamps_nxt[3*a +: 3] = LAMP_YELLOW;
      end
    end
  end

  // State, timer, pointer and lamp registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      grant <= 2'd0;
      last  <= 2'd3;
      lamps <= {4{LAMP_RED}};
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      lamps <= lamps_nxt;
    end
  end

  assign M1    = lamps[2:0];
  assign M2    = lamps[5:3];
  assign MT    = lamps[8:6];
  assign SR    = lamps[11:9];
  assign phase = state;

endmodule
